// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access size codes and FSM state encoding.
package mem_access_stage_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: store replication and byte enables, load lane
// extraction with sign/zero extension, and alignment checking.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  req_offset,
    input  logic [1:0]  req_size,
    input  logic [31:0] wr_data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        misaligned,
    input  logic [1:0]  rsp_offset,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_signed,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        wdata      = wr_data;
        be         = 4'b1111;
        misaligned = 1'b0;
        case (req_size)
            MEM_BYTE: begin
                wdata = {4{wr_data[7:0]}};
                be    = 4'b1000 >> req_offset;
            end
            MEM_HALF: begin
                wdata      = {2{wr_data[15:0]}};
                be         = req_offset[1] ? 4'b0011 : 4'b1100;
                misaligned = req_offset[0];
            end
            default: misaligned = |req_offset;
        endcase
    end

    // Offset 0 is the most significant byte.
    always_comb begin
        case (rsp_offset)
            2'd0:    rd_byte = rd_word[31:24];
            2'd1:    rd_byte = rd_word[23:16];
            2'd2:    rd_byte = rd_word[15:8];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = rsp_offset[1] ? rd_word[15:0] : rd_word[31:16];
        case (rsp_size)
            MEM_BYTE: rd_data = {{24{rsp_signed & rd_byte[7]}}, rd_byte};
            MEM_HALF: rd_data = {{16{rsp_signed & rd_half[15]}}, rd_half};
            default:  rd_data = rd_word;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues req/ack data-memory transactions for loads and
// stores, stalls upstream while waiting, and registers the writeback result.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_ALUres,
    input  logic [31:0] i_op2,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic        i_memSigned,
    output logic        o_stall,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [31:0] o_dm_wdata,
    output logic [3:0]  o_dm_be,
    input  logic        i_dm_ack,
    input  logic [31:0] i_dm_rdata,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_misaligned,
    output logic        o_bus_error
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;

    logic [31:0]       st_wdata;
    logic [3:0]        st_be;
    logic              misaligned;
    logic [31:0]       ld_data;
    logic              is_mem;
    logic              timeout;

    mem_lane_align u_align (
        .req_offset (i_ALUres[1:0]),
        .req_size   (i_memSize),
        .wr_data    (i_op2),
        .wdata      (st_wdata),
        .be         (st_be),
        .misaligned (misaligned),
        .rsp_offset (off_q),
        .rsp_size   (size_q),
        .rsp_signed (signed_q),
        .rd_word    (i_dm_rdata),
        .rd_data    (ld_data)
    );

    assign is_mem  = i_memRead | i_memWrite;
    assign timeout = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        o_stall = 1'b0;
        if (state == ST_IDLE)
            o_stall = i_valid & is_mem & ~misaligned;
        else
            o_stall = ~i_dm_ack & ~timeout;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            size_q       <= MEM_WORD;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            o_dm_req     <= 1'b0;
            o_dm_we      <= 1'b0;
            o_dm_addr    <= '0;
            o_dm_wdata   <= '0;
            o_dm_be      <= 4'b0000;
            o_valid      <= 1'b0;
            o_result     <= '0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_misaligned <= 1'b0;
                    o_bus_error  <= 1'b0;
                    if (!i_valid) begin
                        o_valid <= 1'b0;
                    end else if (!is_mem) begin
                        o_valid  <= 1'b1;
                        o_result <= i_ALUres;
                    end else if (misaligned) begin
                        o_valid      <= 1'b1;
                        o_misaligned <= 1'b1;
                        o_result     <= i_ALUres;
                    end else begin
                        o_valid    <= 1'b0;
                        o_dm_req   <= 1'b1;
                        o_dm_we    <= i_memWrite;
                        o_dm_addr  <= {i_ALUres[31:2], 2'b00};
                        o_dm_wdata <= st_wdata;
                        o_dm_be    <= st_be;
                        size_q     <= i_memSize;
                        signed_q   <= i_memSigned;
                        off_q      <= i_ALUres[1:0];
                        tmo_cnt    <= '0;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack arriving on the timeout cycle still completes normally.
                    if (i_dm_ack) begin
                        o_dm_req <= 1'b0;
                        o_valid  <= 1'b1;
                        o_result <= o_dm_we ? {o_dm_addr[31:2], off_q} : ld_data;
                        state    <= ST_IDLE;
                    end else if (timeout) begin
                        o_dm_req    <= 1'b0;
                        o_valid     <= 1'b1;
                        o_bus_error <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, stores, loads,
// misalignment, timeout, and asynchronous reset during a transaction.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] op2;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        res_valid;
    logic [31:0] result;
    logic        misaligned;
    logic        bus_error;

    int n_cmp = 0;
    int n_err = 0;
    int stalls;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_ALUres     (alu_res),
        .i_op2        (op2),
        .i_memRead    (mem_read),
        .i_memWrite   (mem_write),
        .i_memSize    (mem_size),
        .i_memSigned  (mem_signed),
        .o_stall      (stall),
        .o_dm_req     (dm_req),
        .o_dm_we      (dm_we),
        .o_dm_addr    (dm_addr),
        .o_dm_wdata   (dm_wdata),
        .o_dm_be      (dm_be),
        .i_dm_ack     (dm_ack),
        .i_dm_rdata   (dm_rdata),
        .o_valid      (res_valid),
        .o_result     (result),
        .o_misaligned (misaligned),
        .o_bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        valid      = 1'b0;
        alu_res    = 32'h0;
        op2        = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'b10;
        mem_signed = 1'b0;
        dm_ack     = 1'b0;
        dm_rdata   = 32'h0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] data);
        valid      = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        mem_size   = sz;
        mem_signed = sgn;
        alu_res    = addr;
        op2        = data;
    endtask

    // Load issued at a negedge; ack given on the first BUSY cycle; checks the result.
    task automatic load_one_ack(input string tag, input logic [1:0] sz, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] rdata,
                                input logic [31:0] exp);
        issue(1'b1, 1'b0, sz, sgn, addr, 32'h0);
        @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = rdata;
        @(negedge clk);
        clear_inputs();
        #1;
        chk({tag, "_valid"}, 32'(res_valid), 32'h1);
        chk({tag, "_result"}, result, exp);
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(res_valid), 32'h0);
        chk("rst_req", 32'(dm_req), 32'h0);
        chk("rst_we", 32'(dm_we), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_addr", dm_addr, 32'h0);
        chk("rst_wdata", dm_wdata, 32'h0);
        chk("rst_be", 32'(dm_be), 32'h0);
        chk("rst_flags", {30'h0, misaligned, bus_error}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op, single-cycle latency, no stall
        @(negedge clk);
        issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0);
        #1;
        chk("alu_stall", 32'(stall), 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("alu_valid", 32'(res_valid), 32'h1);
        chk("alu_result", result, 32'h0000_1234);
        chk("alu_flags", {30'h0, misaligned, bus_error}, 32'h0);
        @(negedge clk);
        #1;
        chk("alu_pulse", 32'(res_valid), 32'h0);

        // sb to 0x103, ack on fourth BUSY cycle
        @(negedge clk);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h1234_56AB);
        stalls = 0;
        #1;
        stalls += int'(stall);
        @(negedge clk);
        #1;
        stalls += int'(stall);
        chk("sb_req", 32'(dm_req), 32'h1);
        chk("sb_we", 32'(dm_we), 32'h1);
        chk("sb_addr", dm_addr, 32'h0000_0100);
        chk("sb_be", 32'(dm_be), 32'h1);
        chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        chk("sb_busy_valid", 32'(res_valid), 32'h0);
        @(negedge clk);
        #1;
        stalls += int'(stall);
        @(negedge clk);
        #1;
        stalls += int'(stall);
        @(negedge clk);
        dm_ack = 1'b1;
        #1;
        chk("sb_ack_stall", 32'(stall), 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("sb_stall_cycles", 32'(stalls), 32'd4);
        chk("sb_valid", 32'(res_valid), 32'h1);
        chk("sb_result", result, 32'h0000_0103);
        chk("sb_req_drop", 32'(dm_req), 32'h0);
        @(negedge clk);
        #1;
        chk("sb_pulse", 32'(res_valid), 32'h0);

        // sh to 0x402: low half lanes
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0402, 32'hFFFF_BEEF);
        @(negedge clk);
        #1;
        chk("sh_be", 32'(dm_be), 32'h3);
        chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dm_addr, 32'h0000_0400);
        dm_ack = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        // loads: lane extraction and extension
        load_one_ack("lh_s", 2'b01, 1'b1, 32'h0000_0202, 32'h1234_8001, 32'hFFFF_8001);
        load_one_ack("lh_u", 2'b01, 1'b0, 32'h0000_0202, 32'h1234_8001, 32'h0000_8001);
        load_one_ack("lb_s", 2'b00, 1'b1, 32'h0000_0301, 32'h11F2_3344, 32'hFFFF_FFF2);
        load_one_ack("lbu",  2'b00, 1'b0, 32'h0000_0300, 32'h9922_3344, 32'h0000_0099);
        load_one_ack("lw",   2'b10, 1'b1, 32'h0000_0308, 32'h8765_4321, 32'h8765_4321);

        // misaligned word load: no bus request
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        #1;
        chk("mis_stall", 32'(stall), 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mis_req", 32'(dm_req), 32'h0);
        chk("mis_valid", 32'(res_valid), 32'h1);
        chk("mis_flag", 32'(misaligned), 32'h1);
        chk("mis_result", result, 32'h0000_0006);
        @(negedge clk);

        // misaligned half store
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("mish_flag", 32'(misaligned), 32'h1);
        chk("mish_req", 32'(dm_req), 32'h0);
        @(negedge clk);

        // lw with no ack: abort after 16 BUSY cycles
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        stalls = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            #1;
            stalls += int'(stall);
        end
        chk("tmo_stall_before", 32'(stalls), 32'd15);
        @(negedge clk);
        #1;
        chk("tmo_last_stall", 32'(stall), 32'h0);
        chk("tmo_last_req", 32'(dm_req), 32'h1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("tmo_valid", 32'(res_valid), 32'h1);
        chk("tmo_bus_error", 32'(bus_error), 32'h1);
        chk("tmo_req", 32'(dm_req), 32'h0);
        @(negedge clk);
        #1;
        chk("tmo_pulse", 32'(res_valid), 32'h0);

        // ack on the timeout cycle wins
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0);
        repeat (16) @(negedge clk);
        dm_ack   = 1'b1;
        dm_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        clear_inputs();
        #1;
        chk("tmoack_valid", 32'(res_valid), 32'h1);
        chk("tmoack_bus_error", 32'(bus_error), 32'h0);
        chk("tmoack_result", result, 32'hCAFE_F00D);
        @(negedge clk);

        // asynchronous reset in BUSY
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        #1;
        chk("arst_req_before", 32'(dm_req), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_req_drop", 32'(dm_req), 32'h0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        chk("arst_no_valid", 32'(res_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("arst_no_valid2", 32'(res_valid), 32'h0);
        load_one_ack("post_rst_lw", 2'b10, 1'b0, 32'h0000_0084, 32'h55AA_55AA, 32'h55AA_55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
